// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage core: load-use stalls,
//            ID branch flushes, and data-memory freeze with watchdog.
//            Optional stall/flush performance counters: HAZ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [15:0] c_WD_LIMIT = 16'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_flush_pend;
    logic [15:0] r_wd_cnt;
    logic        r_err;

    logic w_lu;
    logic w_mem_stall;

    assign w_lu = ex_memread_i && (ex_rd_i != 5'd0) &&
                  ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    assign w_mem_stall = mem_req_i && !mem_ack_i;

    // Controls are forced to their idle values while reset is held so that
    // downstream stages never see a stall/flush derived from junk inputs.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        if (rst_i) begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        pc_write_o   = 1'b0;
                        ifid_stall_o = 1'b1;
                        freeze_o     = 1'b1;
                    end else if (w_lu) begin
                        pc_write_o    = 1'b0;
                        ifid_stall_o  = 1'b1;
                        idex_bubble_o = 1'b1;
                    end else if (branch_taken_i || r_flush_pend) begin
                        ifid_flush_o = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    pc_write_o   = 1'b0;
                    ifid_stall_o = 1'b1;
                    freeze_o     = 1'b1;
                end
                default: begin
                    pc_write_o = 1'b1;
                end
            endcase
        end
    end

    assign err_o = r_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_RUN;
            r_flush_pend <= 1'b0;
            r_wd_cnt     <= 16'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state      <= ST_MEM_WAIT;
                        r_wd_cnt     <= 16'd1;
                        r_flush_pend <= r_flush_pend | branch_taken_i;
                    end else if (w_lu) begin
                        // Branch operands are stale under a load-use; ID re-resolves next cycle.
                        r_flush_pend <= r_flush_pend;
                    end else if (branch_taken_i || r_flush_pend) begin
                        r_flush_pend <= 1'b0;
                    end
                end
                ST_MEM_WAIT: begin
                    r_flush_pend <= r_flush_pend | branch_taken_i;
                    if (mem_ack_i) begin
                        r_state  <= ST_RUN;
                        r_wd_cnt <= 16'd0;
                    end else if (r_wd_cnt == c_WD_LIMIT) begin
                        r_state  <= ST_RUN;
                        r_wd_cnt <= 16'd0;
                        r_err    <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write_o && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (ifid_flush_o && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_CNT_W = 16;
`ifdef HAZ_PERF_CNT_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
    logic             ex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;
    logic             pc_write_o, ifid_stall_o, ifid_flush_o;
    logic             idex_bubble_o, freeze_o, err_o;
    logic [c_CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    // {pc_write, ifid_stall, ifid_flush, idex_bubble, freeze, err}
    logic [5:0] w_outs;
    assign w_outs = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, freeze_o, err_o};

    int n_chk  = 0;
    int n_pass = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(c_CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .branch_taken_i(branch_taken_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .pc_write_o(pc_write_o), .ifid_stall_o(ifid_stall_o),
        .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
        .freeze_o(freeze_o), .err_o(err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    // Apply one cycle's inputs after the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic rq, input logic ak);
        @(negedge clk_i);
        ex_memread_i = mr; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        branch_taken_i = br; mem_req_i = rq; mem_ack_i = ak;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        ex_memread_i = 1'b0; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            n_chk++;
            if (w_outs !== 6'b100000) $display("FAIL reset_hold outs=%b exp=%b", w_outs, 6'b100000);
            else n_pass++;
        end
        n_chk++;
        if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0)
            $display("FAIL reset_cnt stall=%0d flush=%0d exp=0/0", stall_cnt_o, flush_cnt_o);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            n_chk++;
            if (w_outs !== 6'b100000) $display("FAIL reset_idle outs=%b exp=%b", w_outs, 6'b100000);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (w_outs !== 6'b010100) $display("FAIL lu_rs2 outs=%b exp=%b", w_outs, 6'b010100);
        else n_pass++;
        idle();
        n_chk++;
        if (w_outs !== 6'b100000) $display("FAIL lu_one_cycle outs=%b exp=%b", w_outs, 6'b100000);
        else n_pass++;
        n_chk++;
        if (stall_cnt_o !== (c_PERF ? 16'd1 : 16'd0))
            $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt_o, c_PERF ? 1 : 0);
        else n_pass++;
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (w_outs !== 6'b100000) $display("FAIL lu_rd0 outs=%b exp=%b", w_outs, 6'b100000);
        else n_pass++;
        drive(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (w_outs !== 6'b010100) $display("FAIL lu_rs1 outs=%b exp=%b", w_outs, 6'b010100);
        else n_pass++;
        drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (w_outs !== 6'b100000) $display("FAIL lu_noload outs=%b exp=%b", w_outs, 6'b100000);
        else n_pass++;
    endtask

    task automatic test_branch_lu();
        do_reset();
        drive(1'b1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if (w_outs !== 6'b010100) $display("FAIL br_lu outs=%b exp=%b", w_outs, 6'b010100);
        else n_pass++;
        drive(1'b0, 5'd0, 5'd9, 5'd1, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if (w_outs !== 6'b101000) $display("FAIL br_flush outs=%b exp=%b", w_outs, 6'b101000);
        else n_pass++;
        idle();
        n_chk++;
        if (w_outs !== 6'b100000) $display("FAIL br_after outs=%b exp=%b", w_outs, 6'b100000);
        else n_pass++;
        n_chk++;
        if (flush_cnt_o !== (c_PERF ? 16'd1 : 16'd0) || stall_cnt_o !== (c_PERF ? 16'd1 : 16'd0))
            $display("FAIL br_cnt flush=%0d stall=%0d exp=%0d/%0d", flush_cnt_o, stall_cnt_o,
                     c_PERF ? 1 : 0, c_PERF ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (w_outs !== 6'b100000) $display("FAIL mem_zero_cost outs=%b exp=%b", w_outs, 6'b100000);
        else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, (c == 2), 1'b1, (c == 4));
            n_chk++;
            if (w_outs !== 6'b010010) $display("FAIL mem_freeze_c%0d outs=%b exp=%b", c, w_outs, 6'b010010);
            else n_pass++;
        end
        idle();
        n_chk++;
        if (w_outs !== 6'b101000) $display("FAIL mem_pend_flush outs=%b exp=%b", w_outs, 6'b101000);
        else n_pass++;
        idle();
        n_chk++;
        if (w_outs !== 6'b100000) $display("FAIL mem_after outs=%b exp=%b", w_outs, 6'b100000);
        else n_pass++;
        n_chk++;
        if (stall_cnt_o !== (c_PERF ? 16'd4 : 16'd0) || flush_cnt_o !== (c_PERF ? 16'd1 : 16'd0))
            $display("FAIL mem_cnt stall=%0d flush=%0d exp=%0d/%0d", stall_cnt_o, flush_cnt_o,
                     c_PERF ? 4 : 0, c_PERF ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (w_outs !== 6'b010010) $display("FAIL wd_enter outs=%b exp=%b", w_outs, 6'b010010);
        else n_pass++;
        for (int c = 1; c <= 8; c++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            n_chk++;
            if (w_outs !== 6'b010010) $display("FAIL wd_wait_c%0d outs=%b exp=%b", c, w_outs, 6'b010010);
            else n_pass++;
        end
        for (int c = 0; c < 3; c++) begin
            idle();
            n_chk++;
            if (w_outs !== 6'b100001) $display("FAIL wd_err_sticky_%0d outs=%b exp=%b", c, w_outs, 6'b100001);
            else n_pass++;
        end
        n_chk++;
        if (stall_cnt_o !== (c_PERF ? 16'd9 : 16'd0))
            $display("FAIL wd_stall_cnt got=%0d exp=%0d", stall_cnt_o, c_PERF ? 9 : 0);
        else n_pass++;
        do_reset();
        idle();
        n_chk++;
        if (w_outs !== 6'b100000) $display("FAIL wd_err_clear outs=%b exp=%b", w_outs, 6'b100000);
        else n_pass++;
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (w_outs !== 6'b010010) $display("FAIL rmf_frozen outs=%b exp=%b", w_outs, 6'b010010);
        else n_pass++;
        rst_i = 1'b0;
        #1;
        n_chk++;
        if (w_outs !== 6'b100000) $display("FAIL rmf_async outs=%b exp=%b", w_outs, 6'b100000);
        else n_pass++;
        mem_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            idle();
            n_chk++;
            if (w_outs !== 6'b100000) $display("FAIL rmf_no_flush_%0d outs=%b exp=%b", c, w_outs, 6'b100000);
            else n_pass++;
        end
        n_chk++;
        if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0)
            $display("FAIL rmf_cnt stall=%0d flush=%0d exp=0/0", stall_cnt_o, flush_cnt_o);
        else n_pass++;
    endtask

    initial begin
        rst_i = 1'b0;
        ex_memread_i = 1'b0; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_watchdog();
        test_reset_mid_freeze();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage core. It drives the stall and flush controls of the IF/ID pipeline register, the PC write enable, and the ID/EX bubble insert. It detects load-use hazards and taken branches resolved in ID, and freezes the whole pipeline while a data-memory access is outstanding. A watchdog guards that freeze, and optional performance counters record stall and flush activity.

## Interface
- MEM_TIMEOUT, 64: max cycles in MEM_WAIT before watchdog abort (2..65535)
- CNT_W, 16: width of performance counters
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_rs1_i  in  5  rs1 index of instruction in ID
- id_rs2_i  in  5  rs2 index of instruction in ID
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination index of instruction in EX
- branch_taken_i  in  1  branch in ID resolved taken
- mem_req_i  in  1  MEM stage issues a data-memory access this cycle
- mem_ack_i  in  1  data memory completes the access
- pc_write_o  out  1  PC update enable
- ifid_stall_o  out  1  hold IF/ID register
- ifid_flush_o  out  1  zero IF/ID register
- idex_bubble_o  out  1  zero ID/EX control fields
- freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- err_o  out  1  sticky watchdog error
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 (with macro only)
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1 (with macro only)

## Operation
- States: RUN, MEM_WAIT. Reset state is RUN. Internal registers: flush_pend=0, wd_cnt=0.
- Load-use hazard (lu) = ex_memread_i & (ex_rd_i≠0) & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i).
- RUN, first matching case in priority order:
  1. mem_req_i & !mem_ack_i: go to MEM_WAIT and set wd_cnt=1. Assert freeze_o, ifid_stall_o. pc_write_o=0. Latch flush_pend |= branch_taken_i.
  2. lu: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1. branch_taken_i is ignored this cycle because its operands are stale; ID re-evaluates next cycle.
  3. branch_taken_i | flush_pend: ifid_flush_o=1 and pc_write_o=1. Clear flush_pend.
  4. Otherwise pc_write_o=1 and all other controls are 0.
- MEM_WAIT:
  - freeze_o=1, ifid_stall_o=1, pc_write_o=0, ifid_flush_o=0, idex_bubble_o=0.
  - Latch flush_pend |= branch_taken_i.
  - On mem_ack_i, return to RUN next cycle.
  - Otherwise, when wd_cnt==MEM_TIMEOUT, set err_o=1 and force a return to RUN. Otherwise wd_cnt increments.
- Control outputs are combinational from state, flush_pend, and inputs. They are never asserted in conflicting pairs: ifid_flush_o and ifid_stall_o are never both 1.
- err_o clears only on reset.

## Timing
- Reset values: every output 0 except pc_write_o=1 (RUN, no inputs active). State RUN, flush_pend=0, wd_cnt=0, counters 0.
- Load-use stall lasts exactly 1 cycle. The next cycle, lu is false because EX now holds a bubble.
- Memory freeze latency:
  - Freeze is asserted in the same cycle as mem_req_i & !mem_ack_i.
  - It lasts until and including the cycle mem_ack_i=1 is seen in MEM_WAIT.
  - The pipeline advances the cycle after that.
- mem_req_i & mem_ack_i in the same cycle in RUN: no freeze and zero-cycle cost.
- A pending flush fires in the first RUN cycle with no memory wait and no lu.
- Watchdog: with MEM_TIMEOUT=N and no ack, err_o rises after N cycles in MEM_WAIT, and state is RUN on the following cycle.
- rst_i low mid-freeze: immediate return to reset values, pending flush discarded.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cnt_o and flush_cnt_o count as specified.
  - Both saturate at all-ones.
- HAZ_PERF_CNT_EN undefined:
  - Both outputs are tied to 0 and no counter flops are synthesized.

## Test plan
- Reset: hold rst_i=0 with random inputs → pc_write_o=1, all other outputs 0. After release, wait 3 idle cycles → outputs unchanged.
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 for 1 cycle → stall/bubble for 1 cycle and stall_cnt_o=1. Repeat with ex_rd_i=0 → no stall.
- Branch during load-use: lu and branch_taken_i both set → no flush that cycle. Next cycle with branch_taken_i=1 → ifid_flush_o=1 and flush_cnt_o=1.
- Memory wait: mem_req_i=1 with ack after 4 cycles, branch_taken_i pulsed in cycle 2 → freeze_o=1 for 4 cycles, then ifid_flush_o=1 on the first RUN cycle.
- Watchdog: MEM_TIMEOUT=8 with ack never given → err_o=1 after 8 cycles, state back to RUN, and err_o stays 1 until reset.
- Reset asserted in cycle 2 of MEM_WAIT with a branch pending → reset values, and no flush after release.
